// File: rtl/rst_pkg.sv
// Shared types and sizing helpers for the reset synchroniser/sequencer.
// Latency: n/a (package only).
// Backpressure: n/a.
package rst_pkg;

  // Sequencer states, 2-bit binary encoded.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    REL  = 2'd2,
    RUN  = 2'd3
  } state_t;

  // Width of the shared hold/gap counter. Clamped to 1 so that
  // HOLD_CYC = GAP_CYC = 1 still yields a legal vector.
  function automatic int cnt_width(input int hold_cyc, input int gap_cyc);
    int m;
    int w;
    m = (hold_cyc > gap_cyc) ? hold_cyc : gap_cyc;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

  // Width of the channel index, never below 1.
  function automatic int idx_width(input int num_ch);
    int w;
    w = $clog2(num_ch);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Synchronises deassertion of an async active-high reset into clk.
// Latency: sync_ok rises SYNC_STAGES edges after rst_async falls; asserts asynchronously.
// Backpressure: none.
module rst_sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_async,
  output logic sync_ok
);

  (* async_reg = "true" *) logic [SYNC_STAGES-1:0] chain_q;

  // Shift ones in after release; any assertion clears the chain at once.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_ok = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_sync.sv
// Reset synchroniser plus ordered per-channel reset release sequencer.
// Latency: rst_out[k] falls SYNC_STAGES+1+HOLD_CYC+k*GAP_CYC edges after rst_async release.
// Backpressure: none; sw_rst_req is a single-cycle pulse honoured outside IDLE.
module rst_seq_sync
  import rst_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYC    = 16,
  parameter int GAP_CYC     = 4
) (
  input  logic              clk,
  input  logic              rst_async,
  input  logic              sw_rst_req,
  output logic [NUM_CH-1:0] rst_out,
  output logic              all_released,
  output logic              busy
);

  localparam int CW = cnt_width(HOLD_CYC, GAP_CYC);
  localparam int IW = idx_width(NUM_CH);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);

  logic              sync_ok;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NUM_CH-1:0] rst_out_q, rst_out_d;
  logic              all_rel_q, all_rel_d;
  logic              busy_q, busy_d;

  rst_sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_async(rst_async),
    .sync_ok  (sync_ok)
  );

  // Next-state, counter, index and output-vector logic for the sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    case (state_q)
      IDLE: begin
        // Software requests are deliberately ignored until the chain releases.
        if (sync_ok) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (sw_rst_req) begin
          rst_out_d = '1;
          cnt_d     = '0;
        end else if (cnt_q == HOLD_LAST) begin
          rst_out_d[0] = 1'b0;
          cnt_d        = '0;
          idx_d        = '0;
          state_d      = (NUM_CH == 1) ? RUN : REL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REL: begin
        if (sw_rst_req) begin
          rst_out_d = '1;
          cnt_d     = '0;
          state_d   = HOLD;
        end else if (cnt_q == GAP_LAST) begin
          // Release the channel after the last one released (idx).
          for (int k = 1; k < NUM_CH; k++) begin
            if (k == int'(idx_q) + 1) rst_out_d[k] = 1'b0;
          end
          idx_d = idx_q + 1'b1;
          cnt_d = '0;
          if (int'(idx_q) + 1 >= NUM_CH - 1) state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (sw_rst_req) begin
          rst_out_d = '1;
          cnt_d     = '0;
          state_d   = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Status flags are registered from the next state so they track rst_out exactly.
    all_rel_d = (rst_out_d == '0);
    busy_d    = (state_d != RUN);
  end

  // State and output registers; async assertion forces everything back to reset.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      all_rel_q <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      all_rel_q <= all_rel_d;
      busy_q    <= busy_d;
    end
  end

  assign rst_out      = rst_out_q;
  assign all_released = all_rel_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_rst_seq_sync.sv
// Directed bench for rst_seq_sync: default-parameter instance plus a minimal-parameter instance.
// Edges are counted from the release of the instance's async reset.
// Outputs sampled 1 time unit after each rising edge.
module tb_rst_seq_sync;

  logic       clk = 1'b0;
  logic       rst1, sw1, rst2, sw2;
  logic [3:0] ro1;
  logic       ar1, b1;
  logic [0:0] ro2;
  logic       ar2, b2;

  int n_tests = 0;
  int n_fail  = 0;
  int ed      = 0;

  typedef struct {
    int         ed;
    logic [3:0] r;
    logic       a;
    logic       b;
  } vec_t;

  vec_t tbl[11];

  always #5 clk = ~clk;

  rst_seq_sync #(
    .SYNC_STAGES(2), .NUM_CH(4), .HOLD_CYC(16), .GAP_CYC(4)
  ) dut1 (
    .clk(clk), .rst_async(rst1), .sw_rst_req(sw1),
    .rst_out(ro1), .all_released(ar1), .busy(b1)
  );

  rst_seq_sync #(
    .SYNC_STAGES(3), .NUM_CH(1), .HOLD_CYC(1), .GAP_CYC(1)
  ) dut2 (
    .clk(clk), .rst_async(rst2), .sw_rst_req(sw2),
    .rst_out(ro2), .all_released(ar2), .busy(b2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    ed++;
  endtask

  task automatic run_to(input int target);
    while (ed < target) tick();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge %0d: got %0h expected %0h", nm, ed, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic [3:0] r, input logic a, input logic b);
    chk({nm, ".rst_out"}, 32'(ro1), 32'(r));
    chk({nm, ".all_released"}, 32'(ar1), 32'(a));
    chk({nm, ".busy"}, 32'(b1), 32'(b));
  endtask

  task automatic chk2(input string nm, input logic r, input logic a, input logic b);
    chk({nm, ".rst_out"}, 32'(ro2), 32'(r));
    chk({nm, ".all_released"}, 32'(ar2), 32'(a));
    chk({nm, ".busy"}, 32'(b2), 32'(b));
  endtask

  task automatic restart1();
    rst1 = 1'b1;
    tick();
    tick();
    rst1 = 1'b0;
    ed   = 0;
  endtask

  initial begin
    tbl[0]  = '{1,  4'b1111, 1'b0, 1'b1};
    tbl[1]  = '{18, 4'b1111, 1'b0, 1'b1};
    tbl[2]  = '{19, 4'b1110, 1'b0, 1'b1};
    tbl[3]  = '{22, 4'b1110, 1'b0, 1'b1};
    tbl[4]  = '{23, 4'b1100, 1'b0, 1'b1};
    tbl[5]  = '{26, 4'b1100, 1'b0, 1'b1};
    tbl[6]  = '{27, 4'b1000, 1'b0, 1'b1};
    tbl[7]  = '{30, 4'b1000, 1'b0, 1'b1};
    tbl[8]  = '{31, 4'b0000, 1'b1, 1'b0};
    tbl[9]  = '{32, 4'b0000, 1'b1, 1'b0};
    tbl[10] = '{40, 4'b0000, 1'b1, 1'b0};

    rst1 = 1'b1; sw1 = 1'b0;
    rst2 = 1'b1; sw2 = 1'b0;
    #1;
    chk1("reset1", 4'b1111, 1'b0, 1'b1);
    chk2("reset2", 1'b1, 1'b0, 1'b1);

    // Power-on release with default parameters.
    tick();
    tick();
    rst1 = 1'b0;
    ed   = 0;
    for (int i = 0; i < 11; i++) begin
      run_to(tbl[i].ed);
      chk1("poweron", tbl[i].r, tbl[i].a, tbl[i].b);
    end

    // Async reassertion between edges 24 and 25 of a fresh sequence.
    restart1();
    run_to(24);
    chk1("midrel_pre", 4'b1100, 1'b0, 1'b1);
    #2 rst1 = 1'b1;
    #1;
    chk1("midrel_async", 4'b1111, 1'b0, 1'b1);
    tick();
    rst1 = 1'b0;
    ed   = 0;
    run_to(18);
    chk1("midrel_r18", 4'b1111, 1'b0, 1'b1);
    run_to(19);
    chk1("midrel_r19", 4'b1110, 1'b0, 1'b1);
    run_to(31);
    chk1("midrel_r31", 4'b0000, 1'b1, 1'b0);

    // Software reset from RUN, accepted at edge 32.
    sw1 = 1'b1;
    tick();
    sw1 = 1'b0;
    chk1("swrun_e", 4'b1111, 1'b0, 1'b1);
    run_to(47);
    chk1("swrun_e15", 4'b1111, 1'b0, 1'b1);
    run_to(48);
    chk1("swrun_e16", 4'b1110, 1'b0, 1'b1);
    run_to(59);
    chk1("swrun_e27", 4'b1000, 1'b0, 1'b1);
    run_to(60);
    chk1("swrun_e28", 4'b0000, 1'b1, 1'b0);

    // Software request held through IDLE (edges 1..3) is ignored.
    restart1();
    sw1 = 1'b1;
    run_to(3);
    sw1 = 1'b0;
    run_to(18);
    chk1("swidle_18", 4'b1111, 1'b0, 1'b1);
    run_to(19);
    chk1("swidle_19", 4'b1110, 1'b0, 1'b1);

    // Software request in HOLD with cnt = 10, sampled at edge 14.
    restart1();
    run_to(13);
    sw1 = 1'b1;
    tick();
    sw1 = 1'b0;
    chk1("swhold_14", 4'b1111, 1'b0, 1'b1);
    run_to(19);
    chk1("swhold_19", 4'b1111, 1'b0, 1'b1);
    run_to(29);
    chk1("swhold_29", 4'b1111, 1'b0, 1'b1);
    run_to(30);
    chk1("swhold_30", 4'b1110, 1'b0, 1'b1);
    run_to(42);
    chk1("swhold_42", 4'b0000, 1'b1, 1'b0);

    // Minimal parameters: single channel released at edge 5.
    rst2 = 1'b0;
    ed   = 0;
    run_to(4);
    chk2("p2_e4", 1'b1, 1'b0, 1'b1);
    run_to(5);
    chk2("p2_e5", 1'b0, 1'b1, 1'b0);

    // rst_async and sw_rst_req together: async reset dominates.
    rst2 = 1'b1;
    sw2  = 1'b1;
    #1;
    chk2("both_async", 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    chk2("both_held", 1'b1, 1'b0, 1'b1);
    rst2 = 1'b0;
    sw2  = 1'b0;
    ed   = 0;
    run_to(2);
    chk2("both_e2", 1'b1, 1'b0, 1'b1);
    run_to(4);
    chk2("both_e4", 1'b1, 1'b0, 1'b1);
    run_to(5);
    chk2("both_e5", 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
